// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences fetch and load/store accesses onto the single
// shared memory port, alternating ownership when both requesters compete.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              grant_if, grant_d;

    // Arbitration: only in IDLE; on a tie the requester that did not own last wins
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && d_req) begin
                grant_d  = (last_owner_q == OWN_IF);
                grant_if = !grant_d;
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    // State and datapath registers, cleared asynchronously so an access is abandoned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            first_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            first_q      <= first_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
        end
    end

    // Next state: capture on grant, count down the read latency, pulse done in RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        first_d      = first_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_if || grant_d) begin
                    state_d      = BUSY;
                    owner_d      = grant_d;
                    last_owner_d = grant_d;
                    addr_d       = grant_d ? d_addr : if_addr;
                    wdata_d      = grant_d ? d_wdata : wdata_q;
                    we_d         = grant_d && d_we;
                    cnt_d        = CW'(MEM_LAT - 1);
                    first_d      = 1'b1;
                end
            end
            BUSY: begin
                first_d = 1'b0;
                if (we_q) begin
                    state_d  = RESP;
                    d_done_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: grant and write strobe are combinational and drop with reset
    always_comb begin
        if_gnt    = grant_if && !reset;
        d_gnt     = grant_d && !reset;
        mem_wr    = (state_q == BUSY) && first_q && we_q && !reset;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_done   = if_done_q;
        d_done    = d_done_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table of single accesses plus hand sequences
// for ties, reset mid-store and back-to-back fetches at two latencies.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_done, d_gnt, d_done, mem_wr;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_gnt1, if_done1, d_gnt1, d_done1, mem_wr1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0004: memf = 32'h8C22_0000;
            32'h0000_0200: memf = 32'h1234_5678;
            32'h0000_0300: memf = 32'hAAAA_5555;
            32'h0000_0080: memf = 32'h0BAD_F00D;
            default:       memf = 32'hCAFE_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign mem_rdata  = memf(mem_addr);
    assign mem_rdata1 = memf(mem_addr1);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
        .if_done(if_done1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1),
        .mem_rdata(mem_rdata1)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] rdata;
    } exp_t;

    vec_t        vecs[6];
    exp_t        sb[$];
    logic [31:0] m_if = '0;
    logic [31:0] m_d  = '0;

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_if = '0;
        m_d  = '0;
        @(posedge clk);
        #1;
    endtask

    // Starts one cycle after a posedge in IDLE; ends likewise in IDLE.
    task automatic run_txn(input vec_t v);
        bit   got;
        exp_t e;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (v.is_d ? d_gnt : if_gnt) got = 1'b1;
            else if (i < 7) begin
                @(posedge clk);
                #1;
            end
        end
        chk("gnt", got, 1);
        if (!got) begin
            if_req = 1'b0;
            d_req  = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        chk("other_gnt", v.is_d ? if_gnt : d_gnt, 0);
        chk("mem_wr_at_gnt", mem_wr, 0);
        e.is_d  = v.is_d;
        e.we    = v.we;
        e.rdata = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 1; k <= v.exp_lat; k++) begin
            @(negedge clk);
            chk("mem_wr", mem_wr, (k == 1) && v.we);
            if (k < v.exp_lat) chk("mem_addr", mem_addr, v.addr);
            if (k == 1 && v.we) chk("mem_wdata", mem_wdata, v.wdata);
            chk("if_done", if_done, (k == v.exp_lat) && !v.is_d);
            chk("d_done", d_done, (k == v.exp_lat) && v.is_d);
            if (k == v.exp_lat) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_entry", 0, 1);
                end else begin
                    e = sb.pop_front();
                    if (e.is_d) begin
                        if (!e.we) m_d = e.rdata;
                    end else begin
                        m_if = e.rdata;
                    end
                    chk("if_rdata", if_rdata, m_if);
                    chk("d_rdata", d_rdata, m_d);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 0, 32'h0000_0004, 32'h0, 32'h8C22_0000, 3};
        vecs[1] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2};
        vecs[2] = '{1, 0, 32'h0000_0200, 32'h0, 32'h1234_5678, 3};
        vecs[3] = '{0, 0, 32'h0000_0300, 32'h0, 32'hAAAA_5555, 3};
        vecs[4] = '{1, 1, 32'h0000_0104, 32'h0123_4567, 32'h0, 2};
        vecs[5] = '{1, 0, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 3};

        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs",
            {if_gnt, if_done, d_gnt, d_done, mem_wr}, 0);
        chk("rst_data", {if_rdata, d_rdata}, 0);
        chk("rst_mem", {mem_addr, mem_wdata}, 0);
        if_req = 1'b1;
        d_req  = 1'b1;
        #1;
        chk("rst_gnt_blocked", {if_gnt, d_gnt}, 0);
        if_req = 1'b0;
        d_req  = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Reset rises during a store's write cycle
        d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h140; d_wdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("abort_gnt", d_gnt, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("abort_wr_before", mem_wr, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_wr_drop", mem_wr, 0);
        chk("abort_flags", {if_gnt, d_gnt, if_done, d_done}, 0);
        chk("abort_data", {if_rdata, d_rdata}, 0);
        chk("abort_mem", {mem_addr, mem_wdata}, 0);
        m_if = '0;
        m_d  = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", {if_done, d_done}, 0);
        end
        @(posedge clk);
        #1;
        run_txn(vecs[3]);

        // Tie after reset: data first, then strict alternation
        do_reset();
        if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("tie_d_gnt", d_gnt, (c % 8) == 0);
            chk("tie_if_gnt", if_gnt, (c % 8) == 4);
            chk("tie_d_done", d_done, (c % 8) == 3);
            chk("tie_if_done", if_done, (c % 8) == 7);
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("tie_if_rdata", if_rdata, 32'h8C22_0000);
        chk("tie_d_rdata", d_rdata, 32'h1234_5678);

        // Continuous fetch at MEM_LAT 2 and 1
        do_reset();
        if_req = 1'b1; if_addr = 32'h4;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("cf2_gnt", if_gnt, (c % 4) == 0);
            chk("cf2_done", if_done, (c % 4) == 3);
            chk("cf1_gnt", if_gnt1, (c % 3) == 0);
            chk("cf1_done", if_done1, (c % 3) == 2);
            chk("cf_wr", {mem_wr, mem_wr1}, 0);
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;
        chk("cf1_rdata", if_rdata1, 32'h8C22_0000);
        chk("cf2_rdata", if_rdata, 32'h8C22_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single shared memory port of the multicycle processor. It accepts access requests from two requesters: instruction fetch (read-only) and data load/store. It grants one access at a time and drives the memory address, write data and write enable for the required number of cycles. It returns read data with a one-cycle done pulse. It sits between the control FSM / datapath and the unified instruction/data memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from address presentation to valid `mem_rdata` for a read; legal range ≥1

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_done`  out  1  one-cycle pulse; fetch data valid
- `if_rdata`  out  DATA_W  fetched word, held until the next fetch done
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted this cycle
- `d_done`  out  1  one-cycle pulse; load data valid or store complete
- `d_rdata`  out  DATA_W  loaded word, held until the next load done
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_wr`  out  1  memory write enable
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY, RESP.
- **Reset values:**
  - State is IDLE.
  - All outputs are 0, including `if_rdata`, `d_rdata`, `mem_addr` and `mem_wdata`.
  - Latency counter is 0.
  - `last_owner` is FETCH.
- **IDLE:**
  - With no request pending, stay in IDLE.
  - With exactly one request pending, grant it.
  - With both pending, grant the requester that is not `last_owner`. After reset, data therefore wins the first tie.
  - Grant is combinational in IDLE. `x_gnt` is 1 for exactly that cycle.
  - On the same clock edge the block captures address, `we` and `wdata` (data port only) into internal registers, records the owner, updates `last_owner`, and enters BUSY.
  - For a fetch, the captured `we` is 0.
- **BUSY:**
  - `mem_addr` and `mem_wdata` are driven from the captured registers.
  - `mem_wr` is 1 only in the first BUSY cycle, and only for a store.
  - For a read, the block stays in BUSY for MEM_LAT cycles, counting down. On the last BUSY cycle, `mem_rdata` is captured into the owner's rdata register.
  - For a store, the block stays in BUSY for 1 cycle regardless of MEM_LAT.
  - Then the block enters RESP.
- **RESP:**
  - The owner's `done` is 1 for one cycle.
  - The block then returns to IDLE.
  - No grant is issued in RESP.
- **Requester rules:**
  - A requester holds `req` and its operands stable until it samples `gnt`=1, then deasserts `req`.
  - `req` high in IDLE after a `done` counts as a new request.
  - `req` outside IDLE is ignored, with no queuing.
- **Held outputs:**
  - `d_rdata` is unchanged by a store.
  - The non-owner's `rdata` is never modified.
- **Reset mid-operation:** the in-flight access is abandoned.
  - `mem_wr`, `gnt` and `done` fall in the same cycle `reset` rises.
  - No `done` is issued for the abandoned access.
- Fetch never asserts `mem_wr`.

## Timing
- Grant at cycle T (IDLE).
- **Read:**
  - BUSY occupies cycles T+1 … T+MEM_LAT.
  - RESP and `done` occur at cycle T+MEM_LAT+1.
  - `rdata` is valid from cycle T+MEM_LAT+1 onward.
- **Store:**
  - `mem_wr` is high at cycle T+1.
  - RESP and `done` occur at cycle T+2.
- Next grant is possible at cycle T+MEM_LAT+2 for a read, or T+3 for a store.
  - Peak read throughput is 1 access per MEM_LAT+2 cycles.
- **Counter:**
  - Width is $clog2(MEM_LAT+1).
  - Loaded with MEM_LAT-1 on grant.
  - Exits BUSY when it reaches 0.
  - No wrap-around.
- `gnt` is a combinational function of state, `req` and `last_owner`. `mem_wr` is a combinational function of state, the first-cycle flag and the captured `we`. All other outputs are registered.

## Test plan
1. **Single fetch:**
   - Stimulus: MEM_LAT=2, `if_req` with `if_addr`=0x4; memory returns 0x8C220000.
   - Required: `if_gnt`=1 at T; `mem_addr`=0x4 at T+1 and T+2; `if_done`=1 only at T+3 with `if_rdata`=0x8C220000; `mem_wr`=0 throughout.
2. **Store:**
   - Stimulus: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF.
   - Required: `d_gnt` at T; `mem_wr`=1 only at T+1 with `mem_addr`=0x100 and `mem_wdata`=0xDEADBEEF; `d_done` at T+2; `d_rdata` unchanged.
3. **Simultaneous requests after reset, both held:**
   - Required: data granted first; fetch granted at the first IDLE after data RESP.
   - Required: on the next tie, data is granted again, giving strict alternation.
4. **Load vs. fetch isolation:**
   - Stimulus: load from 0x200 returning 0x12345678, then fetch returning 0xAAAA5555.
   - Required: `d_rdata` stays 0x12345678 and `if_rdata` becomes 0xAAAA5555.
5. **Reset during a store's BUSY cycle:**
   - Required: `mem_wr` drops the same cycle; no `d_done`; all outputs 0.
   - Required: a fetch request afterwards is granted normally.
6. **Continuous fetch:**
   - Stimulus: `if_req` held high, MEM_LAT=2.
   - Required: `if_gnt` every 4 cycles and `if_done` every 4 cycles.
   - Repeat with MEM_LAT=1: period is 3 cycles.
